// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: six elements over an N = 2^ADDR_W word memory.
// Optional spare-row repair (repair_valid/repair_addr) is enabled with `define MBIST_REPAIR_EN.
module mbist_march_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [7:0]        fail_count,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_re,
   output logic [DATA_W-1:0] mem_wdata,
`ifdef MBIST_REPAIR_EN
   output logic              repair_valid,
   output logic [ADDR_W-1:0] repair_addr,
`endif
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_CMP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [2:0]        ELEM_LAST = 3'd5;
   localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
   localparam logic [DATA_W-1:0] ONES      = {DATA_W{1'b1}};
   localparam logic [DATA_W-1:0] ZEROS     = {DATA_W{1'b0}};

   // Element decode: M3/M4 walk downward, M1/M3 write ones, M2/M4 expect ones.
   function automatic logic elem_down(input logic [2:0] e);
      return (e == 3'd3) || (e == 3'd4);
   endfunction

   function automatic logic elem_wone(input logic [2:0] e);
      return (e == 3'd1) || (e == 3'd3);
   endfunction

   function automatic logic elem_rone(input logic [2:0] e);
      return (e == 3'd2) || (e == 3'd4);
   endfunction

   logic [2:0]        state_r, state_nxt_s;
   logic [2:0]        elem_r, elem_nxt_s, elem_inc_s;
   logic [ADDR_W-1:0] addr_r, addr_nxt_s;
   logic              advance_s, last_addr_s, start_acc_s, mismatch_s;
   logic [DATA_W-1:0] expect_s;
   logic              busy_r, done_r, fail_r, we_r, re_r;
   logic [ADDR_W-1:0] fail_addr_r;
   logic [7:0]        fail_count_r;
   logic [DATA_W-1:0] wdata_r;
`ifdef MBIST_REPAIR_EN
   logic              repair_valid_r;
   logic [ADDR_W-1:0] repair_addr_r;
`endif

   assign elem_inc_s  = elem_r + 3'd1;
   assign start_acc_s = start && ((state_r == S_IDLE) || (state_r == S_DONE));
   assign expect_s    = elem_rone(elem_r) ? ONES : ZEROS;
   assign mismatch_s  = (state_r == S_CMP) && (mem_rdata != expect_s);

   // Next-state sequencing; the write is always the last op of an element at one address.
   always_comb begin
      state_nxt_s = state_r;
      elem_nxt_s  = elem_r;
      addr_nxt_s  = addr_r;
      advance_s   = 1'b0;
      last_addr_s = elem_down(elem_r) ? (addr_r == {ADDR_W{1'b0}}) : (addr_r == ADDR_MAX);
      case (state_r)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nxt_s = S_WRITE;
               elem_nxt_s  = 3'd0;
               addr_nxt_s  = {ADDR_W{1'b0}};
            end else begin
               state_nxt_s = state_r;
            end
         end
         S_WRITE: advance_s = 1'b1;
         S_READ:  state_nxt_s = S_CMP;
         S_CMP: begin
            if (elem_r == ELEM_LAST) begin
               advance_s = 1'b1;
            end else begin
               state_nxt_s = S_WRITE;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
      if (advance_s) begin
         if (!last_addr_s) begin
            addr_nxt_s  = elem_down(elem_r) ? (addr_r - {{(ADDR_W-1){1'b0}}, 1'b1})
                                            : (addr_r + {{(ADDR_W-1){1'b0}}, 1'b1});
            state_nxt_s = (elem_r == 3'd0) ? S_WRITE : S_READ;
         end else if (elem_r == ELEM_LAST) begin
            state_nxt_s = S_DONE;
         end else begin
            elem_nxt_s  = elem_inc_s;
            addr_nxt_s  = elem_down(elem_inc_s) ? ADDR_MAX : {ADDR_W{1'b0}};
            state_nxt_s = S_READ;
         end
      end else begin
         advance_s = 1'b0;
      end
   end

   // State, registered memory strobes and result flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= S_IDLE;
         elem_r         <= 3'd0;
         addr_r         <= {ADDR_W{1'b0}};
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         fail_r         <= 1'b0;
         fail_addr_r    <= {ADDR_W{1'b0}};
         fail_count_r   <= 8'd0;
         we_r           <= 1'b0;
         re_r           <= 1'b0;
         wdata_r        <= ZEROS;
`ifdef MBIST_REPAIR_EN
         repair_valid_r <= 1'b0;
         repair_addr_r  <= {ADDR_W{1'b0}};
`endif
      end else begin
         state_r <= state_nxt_s;
         elem_r  <= elem_nxt_s;
         addr_r  <= addr_nxt_s;
         busy_r  <= (state_nxt_s == S_WRITE) || (state_nxt_s == S_READ) || (state_nxt_s == S_CMP);
         we_r    <= (state_nxt_s == S_WRITE);
         re_r    <= (state_nxt_s == S_READ);
         wdata_r <= ((state_nxt_s == S_WRITE) && elem_wone(elem_nxt_s)) ? ONES : ZEROS;
         if (start_acc_s) begin
            done_r         <= 1'b0;
            fail_r         <= 1'b0;
            fail_addr_r    <= {ADDR_W{1'b0}};
            fail_count_r   <= 8'd0;
`ifdef MBIST_REPAIR_EN
            repair_valid_r <= 1'b0;
            repair_addr_r  <= {ADDR_W{1'b0}};
`endif
         end else begin
            if (state_nxt_s == S_DONE) begin
               done_r <= 1'b1;
            end
            if (mismatch_s) begin
               if (fail_count_r != 8'd255) begin
                  fail_count_r <= fail_count_r + 8'd1;
               end
               if (fail_count_r == 8'd0) begin
                  fail_addr_r <= addr_r;
               end
`ifdef MBIST_REPAIR_EN
               // First failing row goes to the spare; only a different row is fatal.
               if (!repair_valid_r) begin
                  repair_valid_r <= 1'b1;
                  repair_addr_r  <= addr_r;
               end else if (addr_r != repair_addr_r) begin
                  fail_r <= 1'b1;
               end
`else
               fail_r <= 1'b1;
`endif
            end
         end
      end
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign fail       = fail_r;
   assign fail_addr  = fail_addr_r;
   assign fail_count = fail_count_r;
   assign mem_addr   = addr_r;
   assign mem_we     = we_r;
   assign mem_re     = re_r;
   assign mem_wdata  = wdata_r;
`ifdef MBIST_REPAIR_EN
   assign repair_valid = repair_valid_r;
   assign repair_addr  = repair_addr_r;
`endif

endmodule
